// File: rtl/data_memory_bytelane.sv
`timescale 1ns/1ps
// Byte-addressed RV32 data memory for the MEM stage.
// Stores use byte-lane strobes. Loads are combinational and sign- or zero-extended.
// After reset the array is cleared one word per cycle, and ready then rises.
// Bad accesses (misaligned, out of range or illegal size) are dropped.
// The first bad access is recorded in a sticky fault flag and address.
module data_memory_bytelane #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic        RE,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ready,
    output logic        misaligned,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic [31:0] mem [DEPTH_WORDS];

    logic             state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             ready_q, ready_d;
    logic             clr_last;

    logic             fault_q;
    logic [31:0]      fault_addr_q;

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             out_of_range;

    logic             is_byte, is_half, is_word, illegal, zext;
    logic             mis;
    logic             bad;

    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic             store_en;

    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;

    // Address translation.
    // BASE_ADDR is word aligned, so the low offset bits equal the low address bits.
    assign off          = address - BASE_ADDR;
    assign idx          = off[IDX_W+1:2];
    assign lane         = off[1:0];
    assign out_of_range = (address < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));

    // Decode the access size and extension mode from funct3.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (funct3)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            3'b010:         is_word = 1'b1;
            default:        ;
        endcase
    end

    assign illegal = !(is_byte || is_half || is_word);
    assign zext    = funct3[2];

    // An illegal size is reported through bad, not through misaligned.
    assign mis        = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign misaligned = mis;
    assign bad        = mis || out_of_range || illegal;

    // Replicate the store data across the lanes and build the byte strobes.
    always_comb begin
        wr_mask = 4'b0000;
        wr_data = WD;
        if (is_byte) begin
            wr_mask = 4'b0001 << lane;
            wr_data = {4{WD[7:0]}};
        end else if (is_half) begin
            wr_mask = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{WD[15:0]}};
        end else if (is_word) begin
            wr_mask = 4'b1111;
        end
    end

    assign store_en = ready_q && WE && !bad;

    // Clear sequencer: walk every word once, then park in READY until the next reset.
    assign clr_last = (clr_idx_q == IDX_W'(DEPTH_WORDS - 1));

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_last) begin
                    state_d   = ST_READY;
                    ready_d   = 1'b1;
                    clr_idx_d = '0;
                end
            end
            ST_READY: ;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // FSM and clear-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    assign ready = ready_q;

    // Memory array.
    // The array is not reset. Clear writes happen only while the reset is released.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            if (rst) begin
                mem[clr_idx_q] <= '0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Combinational load path.
    // It returns the pre-store value when a load and a store hit the same word in one cycle.
    always_comb begin
        rd_word = out_of_range ? 32'h0 : mem[idx];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

        RD = 32'h0;
        if (ready_q && !bad) begin
            if (is_byte) begin
                RD = zext ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end else if (is_half) begin
                RD = zext ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end else if (is_word) begin
                RD = rd_word;
            end
        end
    end

    // Sticky fault record: the first bad access wins until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else if (ready_q && (WE || RE) && bad && !fault_q) begin
            fault_q      <= 1'b1;
            fault_addr_q <= address;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
`timescale 1ns/1ps
// Bench for data_memory_bytelane.
// Two 8-word instances share the inputs: dut0 at base 0x0 and dut1 at base 0x100.
// Vectors are table-driven. Expected values go through a scoreboard queue.
module tb_data_memory_bytelane;

    logic        clk;
    logic        rst;
    logic        WE, RE;
    logic [2:0]  funct3;
    logic [31:0] address, WD;

    logic [31:0] rd0, faddr0, rd1, faddr1;
    logic        ready0, mis0, fault0, ready1, mis1, fault1;

    int n_vec;
    int n_bad;

    typedef struct {
        bit          rst_before;
        bit          sel;
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_fault;
        logic [31:0] exp_faddr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    data_memory_bytelane #(.DEPTH_WORDS(8), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .WE(WE), .RE(RE), .funct3(funct3), .address(address),
        .WD(WD), .RD(rd0), .ready(ready0), .misaligned(mis0), .fault(fault0),
        .fault_addr(faddr0)
    );

    data_memory_bytelane #(.DEPTH_WORDS(8), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst), .WE(WE), .RE(RE), .funct3(funct3), .address(address),
        .WD(WD), .RD(rd1), .ready(ready1), .misaligned(mis1), .fault(fault1),
        .fault_addr(faddr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rb, bit sel, logic we, logic re, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] wd, logic [31:0] erd,
                                logic emis, logic efault, logic [31:0] efa);
        vec_t v;
        v.rst_before = rb;
        v.sel        = sel;
        v.we         = we;
        v.re         = re;
        v.f3         = f3;
        v.addr       = addr;
        v.wd         = wd;
        v.exp_rd     = erd;
        v.exp_mis    = emis;
        v.exp_fault  = efault;
        v.exp_faddr  = efa;
        return v;
    endfunction

    // Pulse reset for one edge, then wait (bounded) for both instances to finish clearing.
    task automatic do_reset();
        int k;
        WE  = 1'b0;
        RE  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        k = 0;
        while (!(ready0 && ready1) && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reset_ready_cycles", 32'(k), 32'd8);
    endtask

    // Drive a vector just after an edge and push its expectation.
    // Pop and compare the load at mid-cycle, then the fault state after the edge.
    task automatic apply(input vec_t v, input int id);
        vec_t e;
        if (v.rst_before) do_reset();
        WE      = v.we;
        RE      = v.re;
        funct3  = v.f3;
        address = v.addr;
        WD      = v.wd;
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", id), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d rd", id), e.sel ? rd1 : rd0, e.exp_rd);
            chk($sformatf("v%0d misaligned", id), {31'b0, e.sel ? mis1 : mis0},
                {31'b0, e.exp_mis});
            @(posedge clk);
            #1;
            WE = 1'b0;
            RE = 1'b0;
            chk($sformatf("v%0d fault", id), {31'b0, e.sel ? fault1 : fault0},
                {31'b0, e.exp_fault});
            chk($sformatf("v%0d fault_addr", id), e.sel ? faddr1 : faddr0, e.exp_faddr);
        end
    endtask

    initial begin
        int cnt;
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        WE      = 1'b0;
        RE      = 1'b1;
        funct3  = 3'b010;
        address = 32'h0;
        WD      = 32'h0;

        for (int i = 0; i < 8; i++) begin
            dut0.mem[i] = 32'hA5A5_5A00 | 32'(i);
        end

        // Reset state. Garbage in mem[0] must not show up while not ready.
        #1;
        chk("rst_ready", {31'b0, ready0}, 32'd0);
        chk("rst_fault", {31'b0, fault0}, 32'd0);
        chk("rst_fault_addr", faddr0, 32'h0);
        chk("rst_rd_not_ready", rd0, 32'h0);

        // Release, then reset again at clear cycle 3.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        rst     = 1'b0;
        address = 32'h2;
        #1;
        chk("midclear_ready", {31'b0, ready0}, 32'd0);
        chk("not_ready_misaligned", {31'b0, mis0}, 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        // A store during the clear must be ignored.
        WE      = 1'b1;
        RE      = 1'b1;
        funct3  = 3'b010;
        address = 32'h0;
        WD      = 32'hFFFF_FFFF;
        cnt = 0;
        while (!ready0 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        WE = 1'b0;
        RE = 1'b0;
        chk("clear_cycles", 32'(cnt), 32'd8);
        chk("clear_no_fault", {31'b0, fault0}, 32'd0);

        // Every word must read back as zero after the clear.
        for (int i = 0; i < 8; i++) begin
            apply(mk(0, 0, 0, 1, 3'b010, 32'(4 * i), 32'h0, 32'h0, 0, 0, 32'h0), 100 + i);
        end

        //          rb sel we re f3      addr          wd            rd            mis flt faddr
        tbl.push_back(mk(0, 0, 1, 0, 3'b010, 32'h0, 32'h8899_AABB, 32'h0000_0000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 3'b000, 32'h1, 32'h0000_0011, 32'hFFFF_FFAA, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 3'b001, 32'h2, 32'h0000_2233, 32'hFFFF_8899, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b010, 32'h0, 32'h0,         32'h2233_11BB, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 3'b010, 32'h4, 32'h80FF_7F01, 32'h0000_0000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b000, 32'h4, 32'h0,         32'h0000_0001, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b000, 32'h5, 32'h0,         32'h0000_007F, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b000, 32'h6, 32'h0,         32'hFFFF_FFFF, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b100, 32'h6, 32'h0,         32'h0000_00FF, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b001, 32'h6, 32'h0,         32'hFFFF_80FF, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b101, 32'h6, 32'h0,         32'h0000_80FF, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b000, 32'h7, 32'h0,         32'hFFFF_FF80, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b010, 32'h4, 32'h0,         32'h80FF_7F01, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b100, 32'h7, 32'h0,         32'h0000_0080, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b101, 32'h4, 32'h0,         32'h0000_7F01, 0, 0, 32'h0));
        // A store and a load in the same cycle return the old word. The new word shows next cycle.
        tbl.push_back(mk(0, 0, 1, 1, 3'b010, 32'h0, 32'hCAFE_F00D, 32'h2233_11BB, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3'b010, 32'h0, 32'h0,         32'hCAFE_F00D, 0, 0, 32'h0));
        // A misaligned SW is dropped and faults. A later misaligned LH keeps the first address.
        tbl.push_back(mk(0, 0, 1, 0, 3'b010, 32'h6, 32'hDEAD_BEEF, 32'h0000_0000, 1, 1, 32'h6));
        tbl.push_back(mk(0, 0, 0, 1, 3'b010, 32'h4, 32'h0,         32'h80FF_7F01, 0, 1, 32'h6));
        tbl.push_back(mk(0, 0, 0, 1, 3'b001, 32'h3, 32'h0,         32'h0000_0000, 1, 1, 32'h6));
        tbl.push_back(mk(0, 0, 0, 1, 3'b011, 32'h0, 32'h0,         32'h0000_0000, 0, 1, 32'h6));
        tbl.push_back(mk(0, 0, 0, 1, 3'b100, 32'h3, 32'h0,         32'h0000_00CA, 0, 1, 32'h6));
        tbl.push_back(mk(0, 0, 1, 0, 3'b110, 32'h0, 32'h1234_5678, 32'h0000_0000, 0, 1, 32'h6));
        tbl.push_back(mk(0, 0, 0, 1, 3'b010, 32'h0, 32'h0,         32'hCAFE_F00D, 0, 1, 32'h6));
        // Range checks on the instance at base 0x100.
        tbl.push_back(mk(1, 1, 1, 0, 3'b010, 32'h104, 32'h1122_3344, 32'h0,       0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 3'b010, 32'h104, 32'h0,       32'h1122_3344, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 3'b101, 32'h11E, 32'h0,       32'h0000_0000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 3'b010, 32'h120, 32'h0,       32'h0000_0000, 0, 1, 32'h120));
        tbl.push_back(mk(1, 1, 0, 1, 3'b010, 32'h0FC, 32'h0,       32'h0000_0000, 0, 1, 32'h0FC));
        tbl.push_back(mk(1, 1, 1, 0, 3'b011, 32'h100, 32'h55AA_55AA, 32'h0,       0, 1, 32'h100));
        tbl.push_back(mk(0, 1, 0, 1, 3'b010, 32'h100, 32'h0,       32'h0000_0000, 0, 1, 32'h100));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
